// File: rtl/cups_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings,
// controller states and the address width.
package cups_pkg;

  localparam int ADDR_W = 16;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO of addresses. Pushes into a full stack and
// pops from an empty one are ignored; push and pop together are never issued.
module pc_ras
  import cups_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     top_idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // With the count at DEPTH the low bits wrap to 0, so top-1 still lands on DEPTH-1.
  assign top_idx = cnt_q[PW-1:0] - PW'(1);
  assign dout    = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[cnt_q[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/update controller for the program counter: fetch handshake, next-address
// selection (sequential, jump, branch-if-zero, call, return) and the return stack.
module pc_sequencer
  import cups_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stahp,
  input  logic              of,
  input  logic              instr_valid,
  input  logic [2:0]        op,
  input  logic              zero,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pcdrive,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fetch_req,
  output logic              busy,
  output logic              halted,
  output logic              stack_err,
  output logic [1:0]        state_dbg
);

  // Handshake: fetch_req acts as ready; instr_valid is only consumed in a cycle
  // where fetch_req is high, and op/zero/target/pc_cur are sampled at that edge.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ras_dout;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic              go, hold;

  assign pc_inc = pc_cur + ADDR_W'(1);
  assign go     = start && !stahp && !of;
  assign hold   = stahp || of;

  pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst_n (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_next_d = pc_next_q;
    err_d     = err_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (hold) begin
          state_d = ST_HALT;
        end else if (instr_valid) begin
          state_d = ST_UPDATE;
          case (op)
            OP_JUMP: pc_next_d = target;
            OP_BRZ:  pc_next_d = zero ? target : pc_inc;
            OP_CALL: begin
              if (ras_full) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                ras_push  = 1'b1;
                pc_next_d = target;
              end
            end
            OP_RET: begin
              if (ras_empty) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                ras_pop   = 1'b1;
                pc_next_d = ras_dout;
              end
            end
            default: pc_next_d = pc_inc;
          endcase
        end
      end
      ST_UPDATE: begin
        state_d = hold ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        if (go) begin
          state_d = ST_FETCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_next_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_next_q <= pc_next_d;
      err_q     <= err_d;
    end
  end

  // The load strobe is cut combinationally so a late halt/overflow blocks the load.
  assign pcdrive   = (state_q == ST_UPDATE) && !hold;
  assign pc_next   = pc_next_q;
  assign fetch_req = (state_q == ST_FETCH);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_UPDATE);
  assign halted    = (state_q == ST_HALT);
  assign stack_err = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// halt/stack/reset sequences, and randomized programs against a queue-based model.
module tb_pc_sequencer;
  import cups_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stahp = 1'b0;
  logic        of = 1'b0;
  logic        instr_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        zero = 1'b0;
  logic [15:0] target = 16'h0;
  logic [15:0] pc_cur = 16'h0;
  logic        pcdrive, fetch_req, busy, halted, stack_err;
  logic [15:0] pc_next;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_err = 0;

  pc_sequencer #(.RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stahp(stahp), .of(of),
    .instr_valid(instr_valid), .op(op), .zero(zero), .target(target),
    .pc_cur(pc_cur), .pcdrive(pcdrive), .pc_next(pc_next),
    .fetch_req(fetch_req), .busy(busy), .halted(halted),
    .stack_err(stack_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pcdrive"},   {31'd0, pcdrive},   32'd0);
    chk({tag, "_pc_next"},   {16'd0, pc_next},   32'd0);
    chk({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_halted"},    {31'd0, halted},    32'd0);
    chk({tag, "_stack_err"}, {31'd0, stack_err}, 32'd0);
    chk({tag, "_state"},     {30'd0, state_dbg}, {30'd0, ST_IDLE});
  endtask

  // Presents one instruction on the first FETCH cycle and checks the outcome.
  task automatic issue(input string tag, input logic [2:0] o, input logic z,
                       input logic [15:0] t, input logic [15:0] pc,
                       input logic exp_err, input logic [15:0] exp_pc);
    chk({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd1);
    pc_cur = pc; op = o; zero = z; target = t;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    if (!exp_err) begin
      chk({tag, "_pcdrive"}, {31'd0, pcdrive}, 32'd1);
      chk({tag, "_pc_next"}, {16'd0, pc_next}, {16'd0, exp_pc});
      step();
      chk({tag, "_pcdrive_off"}, {31'd0, pcdrive}, 32'd0);
      chk({tag, "_pc_hold"}, {16'd0, pc_next}, {16'd0, exp_pc});
    end else begin
      chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
      chk({tag, "_stack_err"}, {31'd0, stack_err}, 32'd1);
      chk({tag, "_no_pcdrive"}, {31'd0, pcdrive}, 32'd0);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic        err;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  // Reference model state for the random phase.
  logic [15:0] ras_q[$];

  initial begin
    logic [15:0] m_pc, m_exp, t;
    logic [2:0]  o;
    logic        z, m_err;
    int          w;

    tbl[0] = '{OP_NEXT, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001};
    tbl[1] = '{OP_NEXT, 1'b0, 16'h0000, 16'h0001, 1'b0, 16'h0002};
    tbl[2] = '{OP_NEXT, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'h0003};
    tbl[3] = '{OP_JUMP, 1'b0, 16'h0100, 16'h0003, 1'b0, 16'h0100};
    tbl[4] = '{OP_BRZ,  1'b0, 16'h0200, 16'h0100, 1'b0, 16'h0101};
    tbl[5] = '{OP_BRZ,  1'b1, 16'h0200, 16'h0101, 1'b0, 16'h0200};
    tbl[6] = '{OP_CALL, 1'b0, 16'h0040, 16'h0010, 1'b0, 16'h0040};
    tbl[7] = '{OP_RET,  1'b0, 16'h1234, 16'h0040, 1'b0, 16'h0011};
    tbl[8] = '{3'd6,    1'b1, 16'h5555, 16'h0011, 1'b0, 16'h0012};
    tbl[9] = '{OP_NEXT, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000};

    // Reset state, then an IDLE start blocked by halt request.
    #2;
    chk_reset_vals("por");
    reset = 1'b1;
    step();
    stahp = 1'b1;
    pulse_start();
    chk("idle_blocked", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    stahp = 1'b0;
    pulse_start();
    chk("start_fetch", {30'd0, state_dbg}, {30'd0, ST_FETCH});
    chk("start_busy", {31'd0, busy}, 32'd1);

    foreach (tbl[i]) begin
      issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].z, tbl[i].tgt, tbl[i].pc,
            tbl[i].err, tbl[i].exp);
    end

    // Five nested calls overflow the 4-deep stack; contents survive the halt.
    do_reset();
    pulse_start();
    for (int k = 1; k <= 4; k++) begin
      issue($sformatf("call%0d", k), OP_CALL, 1'b0, 16'(k * 16'h0010),
            16'(k * 16'h0100), 1'b0, 16'(k * 16'h0010));
    end
    issue("call5", OP_CALL, 1'b0, 16'h0050, 16'h0500, 1'b1, 16'h0000);
    step();
    chk("call5_still_halted", {31'd0, halted}, 32'd1);
    chk("call5_no_pcdrive2", {31'd0, pcdrive}, 32'd0);
    pulse_start();
    chk("call5_restart_err", {31'd0, stack_err}, 32'd0);
    for (int k = 4; k >= 1; k--) begin
      issue($sformatf("ret%0d", k), OP_RET, 1'b0, 16'h0, 16'h0777, 1'b0,
            16'(k * 16'h0100 + 1));
    end
    issue("ret_empty", OP_RET, 1'b0, 16'h0, 16'h0777, 1'b1, 16'h0000);
    pulse_start();
    chk("ret_empty_clear", {31'd0, stack_err}, 32'd0);
    chk("ret_empty_fetch", {31'd0, fetch_req}, 32'd1);

    // Halt request and overflow arriving during UPDATE.
    for (int k = 0; k < 2; k++) begin
      pc_cur = 16'h0030; op = OP_NEXT; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk($sformatf("gate%0d_pre", k), {31'd0, pcdrive}, 32'd1);
      if (k == 0) stahp = 1'b1; else of = 1'b1;
      #1;
      chk($sformatf("gate%0d_pcdrive", k), {31'd0, pcdrive}, 32'd0);
      step();
      chk($sformatf("gate%0d_halted", k), {31'd0, halted}, 32'd1);
      chk($sformatf("gate%0d_busy", k), {31'd0, busy}, 32'd0);
      pulse_start();
      chk($sformatf("gate%0d_blocked", k), {31'd0, halted}, 32'd1);
      stahp = 1'b0; of = 1'b0;
      pulse_start();
      chk($sformatf("gate%0d_resume", k), {31'd0, fetch_req}, 32'd1);
    end

    // Halt request while waiting in FETCH wins over a valid instruction.
    stahp = 1'b1; instr_valid = 1'b1; op = OP_JUMP; target = 16'h0ABC;
    step();
    instr_valid = 1'b0; stahp = 1'b0;
    chk("fetch_stahp_halt", {31'd0, halted}, 32'd1);
    chk("fetch_stahp_pcnext", {16'd0, pc_next}, 32'h0031);
    pulse_start();

    // Asynchronous reset in the middle of a FETCH cycle.
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    #3;
    reset = 1'b1;
    step();
    chk("async_stay_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Random programs against the queue model.
    do_reset();
    pulse_start();
    ras_q.delete();
    m_pc = 16'($urandom);
    for (int n = 0; n < 150; n++) begin
      w = $urandom_range(0, 2);
      for (int j = 0; j < w; j++) begin
        step();
        chk("rnd_wait_fetch", {31'd0, fetch_req}, 32'd1);
        chk("rnd_wait_nodrive", {31'd0, pcdrive}, 32'd0);
      end
      o = 3'($urandom_range(0, 7));
      z = 1'($urandom_range(0, 1));
      t = 16'($urandom);
      if ($urandom_range(0, 9) == 0) m_pc = 16'hFFFF;
      m_err = 1'b0;
      m_exp = m_pc + 16'd1;
      case (o)
        OP_JUMP: m_exp = t;
        OP_BRZ:  m_exp = z ? t : m_pc + 16'd1;
        OP_CALL: begin
          if (ras_q.size() == DEPTH) m_err = 1'b1;
          else begin ras_q.push_back(m_pc + 16'd1); m_exp = t; end
        end
        OP_RET: begin
          if (ras_q.size() == 0) m_err = 1'b1;
          else m_exp = ras_q.pop_back();
        end
        default: ;
      endcase
      issue("rnd", o, z, t, m_pc, m_err, m_exp);
      if (m_err) begin
        pulse_start();
        chk("rnd_recover", {31'd0, stack_err}, 32'd0);
      end else begin
        m_pc = m_exp;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
